watch_core: RTL and testbench
=============================

// Module: watch_core
// PURPOSE
//  Parametrised up/down time-keeping core for the stopwatch/clock display path.
//  Divides the system clock to a sub-second tick and cascades it through
//  sub-second, second, minute and hour fields. Supports count-up (stopwatch),
//  count-down (timer) with expiry pulse, and parallel preset of H:M:S.
//  Feeds the 7-bit digit pair and blink dot to the FND/display controller.
// PARAMETERS
//  CLK_HZ    100_000_000  system clock frequency
//  TICK_HZ   100          sub-second ticks per second (2..100)
//  HOUR_MAX  24           hour field modulus (2..100)
// PORTS
//  clk       in   1  system clock
//  reset     in   1  synchronous, active-high reset
//  run       in   1  level: 1 = count, 0 = hold
//  dir       in   1  0 = count up, 1 = count down; sampled only while run=0
//  clear     in   1  pulse: zero all fields
//  load      in   1  pulse: preset fields from load_* (ignored while run=1)
//  load_hour in   7  preset hour
//  load_min  in   7  preset minute
//  load_sec  in   7  preset second
//  disp_sel  in   1  0 = sec/sub-sec, 1 = hour/min
//  digit_h   out  7  high display field
//  digit_l   out  7  low display field
//  dot       out  1  blink dot, toggles each second boundary
//  running   out  1  1 while counting is active
//  done      out  1  one-cycle pulse when down-count reaches 00:00:00.00
// BEHAVIOUR
//  - Reset (sync, all regs): fields=0, prescaler=0, dot=0, running=0, done=0,
//    expired=0, dir_q=0 (up).
//  - Prescaler counts 0..CLK_HZ/TICK_HZ-1 only while running=1; tick asserted
//    one cycle at terminal count. Prescaler held (not cleared) while stopped.
//  - running = run & ~expired. dir_q latched from dir on every cycle run=0.
//  - Up: on tick, sub +1; sub==TICK_HZ-1 wraps to 0 and carries to sec (mod
//    60) -> min (mod 60) -> hour (mod HOUR_MAX). Hour wraps to 0 silently.
//  - Down: on tick, sub -1 with borrow; 0 wraps to modulus-1. On tick with all
//    fields 0 (already at zero): fields stay 0, done=1 for that cycle, expired
//    set; counting stays frozen until clear or load. Reaching zero is not done.
//  - Fields update the cycle after tick; all carries resolve in that one cycle.
//  - dot toggles in the cycle sub wraps (either direction).
//  - Priority per cycle: reset > clear > load > tick.
//    clear: fields=0, prescaler=0, expired=0, dot=0; allowed while running.
//    load (run=0 only): hour/min/sec <= inputs, sub=0, prescaler=0, expired=0;
//    inputs >= modulus saturate to modulus-1. load with run=1 ignored.
//  - clear or load coincident with tick: tick discarded, no done pulse.
//  - digit_h/digit_l: combinational mux of current field registers by disp_sel
//    (0 -> sec/sub, 1 -> hour/min); zero latency on disp_sel change.
//  - run deasserted mid-second: fields and prescaler phase hold; resume exact.
//  - reset mid-count: everything returns to reset values on the next edge.
// STRUCTURE
//  - watch_pkg: DIR_UP/DIR_DOWN, DISP_SEC_SUB/DISP_HOUR_MIN, FIELD_W=7,
//    SEC_MOD=60, MIN_MOD=60.
//  - Sub-module time_field (#MOD): 7-bit up/down counter with en, dir, clr,
//    ld/ld_val (saturating), carry_out (wrap up or borrow down), is_zero.
//    Four instances chained by carry_out; prescaler and expiry logic inline.
// TESTING  (bench params CLK_HZ=1000, TICK_HZ=10, HOUR_MAX=24 -> tick/100 clk)
//  1. Up from reset, run=1 for 10 ticks -> sec=1, sub=0, dot=1; disp_sel=0
//     shows digit_h=1, digit_l=0.
//  2. load 23:59:59, run up 10 ticks -> all fields 0 (hour wrap), no done.
//  3. load 00:00:01, dir=1, run -> after 10 ticks 00:00:00.00; next tick done
//     pulses 1 cycle, running=0, fields stay 0 with run held 1.
//  4. load sec=75, min=60, hour=30 -> fields 59/59/23; load with run=1 ignored.
//  5. run 55 clk mid-tick, run=0 for 500 clk, run=1 -> next tick after 45 clk.
//  6. clear on tick cycle while running -> all 0, dot=0; reset mid-count ->
//     all outputs 0 next edge.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared constants and encodings for the watch time-keeping core.
// Field width, second/minute moduli, direction and display-select codes.
package watch_pkg;

    localparam int FIELD_W = 7;
    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        DISP_SEC_SUB  = 1'b0,
        DISP_HOUR_MIN = 1'b1
    } disp_e;

endpackage

// File: rtl/watch_core_time_field.sv
// One modulo-MOD time field: up/down count, clear, saturating preset.
// Ports: clk, reset, en, dir, clr, ld, ld_val -> q, carry_out, is_zero.
module time_field
    import watch_pkg::*;
#(
    parameter int MOD = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               dir,
    input  logic               clr,
    input  logic               ld,
    input  logic [FIELD_W-1:0] ld_val,
    output logic [FIELD_W-1:0] q,
    output logic               carry_out,
    output logic               is_zero
);

    localparam logic [FIELD_W-1:0] TOP = FIELD_W'(MOD - 1);

    assign is_zero = (q == '0);

    // Carry on up-wrap at TOP, borrow on down-wrap at zero.
    assign carry_out = en & (dir ? is_zero : (q == TOP));

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= (ld_val > TOP) ? TOP : ld_val;
        end else if (en) begin
            if (dir) begin
                q <= is_zero ? TOP : q - 1'b1;
            end else begin
                q <= (q == TOP) ? '0 : q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/watch_core.sv
// Up/down time-keeping core: prescaler, sub/sec/min/hour chain, display mux.
// Ports: clk, reset, run, dir, clear, load, load_* in; digit_h/l, dot, running, done out.
module watch_core
    import watch_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_HZ  = 100,
    parameter int HOUR_MAX = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               dir,
    input  logic               clear,
    input  logic               load,
    input  logic [FIELD_W-1:0] load_hour,
    input  logic [FIELD_W-1:0] load_min,
    input  logic [FIELD_W-1:0] load_sec,
    input  logic               disp_sel,
    output logic [FIELD_W-1:0] digit_h,
    output logic [FIELD_W-1:0] digit_l,
    output logic               dot,
    output logic               running,
    output logic               done
);

    localparam int PRESC = CLK_HZ / TICK_HZ;
    localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] P_TOP = PW'(PRESC - 1);

    logic [PW-1:0]      presc;
    logic               expired;
    logic               dir_q;
    logic               tick;
    logic               tick_eff;
    logic               ld_eff;
    logic               all_zero;
    logic               expire_now;
    logic               sub_en;
    logic [FIELD_W-1:0] sub_q, sec_q, min_q, hour_q;
    logic               c_sub, c_sec, c_min;
    logic               hour_carry_unused;
    logic               z_sub, z_sec, z_min, z_hour;

    assign running  = run & ~expired;
    assign tick     = running & (presc == P_TOP);
    assign ld_eff   = load & ~run;
    // clear/load win over a coincident tick; the tick is dropped.
    assign tick_eff = tick & ~clear & ~ld_eff;
    assign all_zero = z_sub & z_sec & z_min & z_hour;
    // A down tick that finds 00:00:00.00 expires instead of counting.
    assign expire_now = tick_eff & dir_q & all_zero;
    assign sub_en     = tick_eff & ~expire_now;

    time_field #(.MOD(TICK_HZ)) u_sub (
        .clk(clk), .reset(reset), .en(sub_en), .dir(dir_q),
        .clr(clear), .ld(ld_eff), .ld_val('0),
        .q(sub_q), .carry_out(c_sub), .is_zero(z_sub)
    );

    time_field #(.MOD(SEC_MOD)) u_sec (
        .clk(clk), .reset(reset), .en(c_sub), .dir(dir_q),
        .clr(clear), .ld(ld_eff), .ld_val(load_sec),
        .q(sec_q), .carry_out(c_sec), .is_zero(z_sec)
    );

    time_field #(.MOD(MIN_MOD)) u_min (
        .clk(clk), .reset(reset), .en(c_sec), .dir(dir_q),
        .clr(clear), .ld(ld_eff), .ld_val(load_min),
        .q(min_q), .carry_out(c_min), .is_zero(z_min)
    );

    time_field #(.MOD(HOUR_MAX)) u_hour (
        .clk(clk), .reset(reset), .en(c_min), .dir(dir_q),
        .clr(clear), .ld(ld_eff), .ld_val(load_hour),
        .q(hour_q), .carry_out(hour_carry_unused), .is_zero(z_hour)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            presc   <= '0;
            expired <= 1'b0;
            dir_q   <= DIR_UP;
            dot     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= expire_now;
            if (!run) begin
                dir_q <= dir;
            end
            if (clear) begin
                presc   <= '0;
                expired <= 1'b0;
                dot     <= 1'b0;
            end else if (ld_eff) begin
                presc   <= '0;
                expired <= 1'b0;
            end else begin
                // Prescaler phase is held, not reset, while stopped.
                if (running) begin
                    presc <= tick ? '0 : presc + 1'b1;
                end
                if (expire_now) begin
                    expired <= 1'b1;
                end
                if (c_sub) begin
                    dot <= ~dot;
                end
            end
        end
    end

    assign digit_h = (disp_sel == DISP_HOUR_MIN) ? hour_q : sec_q;
    assign digit_l = (disp_sel == DISP_HOUR_MIN) ? min_q  : sub_q;

endmodule

// File: tb/tb_watch_core.sv
// Randomised and directed bench for watch_core against a total-time model.
// Model keeps time as one integer count of sub-second ticks.
module tb_watch_core;

    localparam int CLK_HZ   = 1000;
    localparam int TICK_HZ  = 10;
    localparam int HOUR_MAX = 24;
    localparam int PRESC    = CLK_HZ / TICK_HZ;
    localparam int TOTAL    = HOUR_MAX * 3600 * TICK_HZ;

    logic       clk = 1'b0;
    logic       reset, run, dir, clear, load, disp_sel;
    logic [6:0] load_hour, load_min, load_sec;
    logic [6:0] digit_h, digit_l;
    logic       dot, running, done;

    watch_core #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .HOUR_MAX(HOUR_MAX)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .dir(dir),
        .clear(clear), .load(load), .load_hour(load_hour),
        .load_min(load_min), .load_sec(load_sec),
        .disp_sel(disp_sel), .digit_h(digit_h), .digit_l(digit_l),
        .dot(dot), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: elapsed ticks, prescaler phase, flags.
    int m_t, m_ph;
    bit m_exp, m_dirq, m_dot, m_done;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(int v, int m);
        return (v >= m) ? m - 1 : v;
    endfunction

    task automatic model_step();
        bit rn, tk;
        rn = run && !m_exp;
        tk = rn && (m_ph == PRESC - 1);
        m_done = 1'b0;
        if (reset) begin
            m_t = 0; m_ph = 0; m_exp = 0; m_dirq = 0; m_dot = 0;
        end else begin
            if (rn) m_ph = tk ? 0 : m_ph + 1;
            if (clear) begin
                m_t = 0; m_ph = 0; m_exp = 0; m_dot = 0;
            end else if (load && !run) begin
                m_t = ((sat(int'(load_hour), HOUR_MAX) * 60
                      + sat(int'(load_min), 60)) * 60
                      + sat(int'(load_sec), 60)) * TICK_HZ;
                m_ph = 0; m_exp = 0;
            end else if (tk) begin
                if (!m_dirq) begin
                    m_t = (m_t + 1) % TOTAL;
                    if (m_t % TICK_HZ == 0) m_dot = !m_dot;
                end else if (m_t == 0) begin
                    m_done = 1'b1; m_exp = 1'b1;
                end else begin
                    if (m_t % TICK_HZ == 0) m_dot = !m_dot;
                    m_t = m_t - 1;
                end
            end
            if (!run) m_dirq = dir;
        end
    endtask

    function automatic logic [16:0] model_out();
        int sub, sec, mn, hr;
        sub = m_t % TICK_HZ;
        sec = (m_t / TICK_HZ) % 60;
        mn  = (m_t / (TICK_HZ * 60)) % 60;
        hr  = m_t / (TICK_HZ * 3600);
        return {disp_sel ? 7'(hr) : 7'(sec),
                disp_sel ? 7'(mn) : 7'(sub),
                m_dot, run && !m_exp, m_done};
    endfunction

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_eq("cyc", {digit_h, digit_l, dot, running, done}, model_out());
    endtask

    task automatic cycles(int n);
        repeat (n) cyc();
    endtask

    task automatic do_load(int h, int m, int s);
        load_hour = 7'(h); load_min = 7'(m); load_sec = 7'(s);
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        int k;
        reset = 1; run = 0; dir = 0; clear = 0; load = 0; disp_sel = 0;
        load_hour = 0; load_min = 0; load_sec = 0;
        cycles(2);
        reset = 0;
        cyc();
        check_eq("rst_dig", {digit_h, digit_l}, 14'd0);
        check_eq("rst_flags", {dot, running, done}, 3'd0);

        // 1: count up ten ticks from reset.
        run = 1;
        cycles(1000);
        check_eq("t1_sec", digit_h, 7'd1);
        check_eq("t1_sub", digit_l, 7'd0);
        check_eq("t1_dot", dot, 1'b1);
        disp_sel = 1; #1;
        check_eq("t1_hm", {digit_h, digit_l}, 14'd0);
        disp_sel = 0;

        // 2: hour wrap from 23:59:59.
        run = 0;
        do_load(23, 59, 59);
        run = 1;
        cycles(1000);
        check_eq("t2_ss", {digit_h, digit_l}, 14'd0);
        disp_sel = 1; #1;
        check_eq("t2_hm", {digit_h, digit_l}, 14'd0);
        check_eq("t2_done", done, 1'b0);
        disp_sel = 0;

        // 3: down-count to zero then expiry pulse.
        run = 0; dir = 1;
        do_load(0, 0, 1);
        run = 1;
        cycles(1000);
        check_eq("t3_zero", {digit_h, digit_l}, 14'd0);
        check_eq("t3_nodone", done, 1'b0);
        cycles(99);
        check_eq("t3_pre", done, 1'b0);
        cyc();
        check_eq("t3_done", done, 1'b1);
        check_eq("t3_run", running, 1'b0);
        cyc();
        check_eq("t3_pulse", done, 1'b0);
        check_eq("t3_hold", {digit_h, digit_l}, 14'd0);

        // 4: saturating load, load ignored while running.
        run = 0; dir = 0;
        do_load(30, 60, 75);
        disp_sel = 1; #1;
        check_eq("t4_hm", {digit_h, digit_l}, {7'd23, 7'd59});
        disp_sel = 0; #1;
        check_eq("t4_ss", {digit_h, digit_l}, {7'd59, 7'd0});
        run = 1;
        do_load(1, 2, 3);
        disp_sel = 1; #1;
        check_eq("t4_ign", {digit_h, digit_l}, {7'd23, 7'd59});
        disp_sel = 0;

        // 5: pause mid-tick resumes with exact phase.
        run = 0; clear = 1;
        cyc();
        clear = 0; run = 1;
        cycles(55);
        run = 0;
        cycles(500);
        check_eq("t5_hold", digit_l, 7'd0);
        run = 1;
        k = 0;
        while (digit_l == 7'd0 && k < 200) begin
            cyc();
            k++;
        end
        check_eq("t5_lat", k, 45);

        // 6: clear on a tick cycle, then reset mid-count.
        cycles(1000);
        check_eq("t6_dot", dot, 1'b1);
        k = 0;
        while (m_ph != PRESC - 1 && k < 200) begin
            cyc();
            k++;
        end
        check_eq("t6_find", (k < 200), 1'b1);
        clear = 1;
        cyc();
        clear = 0;
        check_eq("t6_clr", {digit_h, digit_l, dot}, 15'd0);
        cycles(337);
        reset = 1; run = 0;
        cyc();
        reset = 0;
        check_eq("t6_rst", {digit_h, digit_l, dot, running, done}, 17'd0);

        // Random phase.
        for (int i = 0; i < 40000; i++) begin
            if ($urandom_range(0, 1499) == 0) run = ~run;
            dir      = 1'($urandom_range(0, 1));
            disp_sel = 1'($urandom_range(0, 1));
            clear    = ($urandom_range(0, 2999) == 0);
            reset    = ($urandom_range(0, 9999) == 0);
            load     = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 1) == 1) begin
                load_hour = 0; load_min = 0;
                load_sec  = 7'($urandom_range(0, 2));
            end else begin
                load_hour = 7'($urandom_range(0, 127));
                load_min  = 7'($urandom_range(0, 127));
                load_sec  = 7'($urandom_range(0, 127));
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
